// File: rtl/noc_deser_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : noc_deser_ctrl
//  Purpose  : Frame sequencer for the NoC link 32-bit deserializer. Paces bit
//             sampling, realigns on start of frame, parses the header length
//             and forwards payload words through a one-entry valid/ready buffer.
//  Options  : NOC_DESER_HDR_CHECK_EN adds an 8'hA5 header magic check and the
//             sticky hdr_err output.
//  Revision : 1.0  initial release
// ============================================================================
module noc_deser_ctrl #(
  parameter int CLKS_PER_BIT = 4,
  parameter int WORDS_MAX    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sof,
  input  logic        done_word,
  input  logic [31:0] parallel_in,
  output logic        shift_en,
  output logic        deser_reset,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        busy,
  output logic        len_err,
  output logic        overflow_err
`ifdef NOC_DESER_HDR_CHECK_EN
  ,
  output logic        hdr_err
`endif
);

  localparam int c_PHASE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(CLKS_PER_BIT - 1);
  localparam logic [c_PHASE_W-1:0] c_PHASE_MID  = c_PHASE_W'(CLKS_PER_BIT / 2);
  localparam logic [7:0]           c_WORDS_MAX  = 8'(WORDS_MAX);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_ALIGN   = 2'd1;
  localparam logic [1:0] c_ST_HEADER  = 2'd2;
  localparam logic [1:0] c_ST_PAYLOAD = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [c_PHASE_W-1:0] r_phase;
  logic [7:0]           r_wcnt;
  logic [31:0]          r_word_out;
  logic                 r_word_valid;
  logic                 r_word_last;
  logic                 r_len_err;
  logic                 r_ovf_err;

  logic w_pacing;
  logic w_hdr_done;
  logic w_pay_done;
  logic w_len_zero;
  logic w_len_big;
  logic w_hdr_bad;
  logic w_hdr_accept;
  logic w_pay_last;
  logic w_buf_load;
  logic w_buf_drop;

  // A same-cycle sof aborts the frame, so it masks any done_word.
  assign w_pacing   = (r_state == c_ST_HEADER) || (r_state == c_ST_PAYLOAD);
  assign w_hdr_done = (r_state == c_ST_HEADER)  && done_word && !sof;
  assign w_pay_done = (r_state == c_ST_PAYLOAD) && done_word && !sof;
  assign w_len_zero = (parallel_in[7:0] == 8'd0);
  assign w_len_big  = (parallel_in[7:0] > c_WORDS_MAX);

`ifdef NOC_DESER_HDR_CHECK_EN
  localparam logic [7:0] c_MAGIC = 8'hA5;
  logic r_hdr_err;
  assign w_hdr_bad = (parallel_in[31:24] != c_MAGIC);
  assign hdr_err   = r_hdr_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hdr_err <= 1'b0;
    end else if (w_hdr_done && w_hdr_bad) begin
      r_hdr_err <= 1'b1;
    end
  end
`else
  assign w_hdr_bad = 1'b0;
`endif

  assign w_hdr_accept = w_hdr_done && !w_hdr_bad && !w_len_zero && !w_len_big;
  assign w_pay_last   = (r_wcnt == 8'd1);
  assign w_buf_load   = w_pay_done && (!r_word_valid || word_ready);
  assign w_buf_drop   = w_pay_done && r_word_valid && !word_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (sof) begin
      w_next_state = c_ST_ALIGN;
    end else begin
      case (r_state)
        c_ST_IDLE:    w_next_state = c_ST_IDLE;
        c_ST_ALIGN:   w_next_state = c_ST_HEADER;
        c_ST_HEADER: begin
          if (done_word) begin
            w_next_state = w_hdr_accept ? c_ST_PAYLOAD : c_ST_IDLE;
          end
        end
        c_ST_PAYLOAD: begin
          if (done_word && w_pay_last) begin
            w_next_state = c_ST_IDLE;
          end
        end
        default:      w_next_state = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != c_ST_IDLE);
    deser_reset = (r_state == c_ST_ALIGN);
    shift_en    = w_pacing && (r_phase == c_PHASE_MID);
  end

  // Phase is held at zero outside the pacing states so HEADER always starts at 0.
  always_ff @(posedge clk) begin
    if (reset || !w_pacing) begin
      r_phase <= '0;
    end else if (r_phase == c_PHASE_LAST) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt <= 8'd0;
    end else if (w_hdr_accept) begin
      r_wcnt <= parallel_in[7:0];
    end else if (w_pay_done) begin
      r_wcnt <= r_wcnt - 8'd1;
    end
  end

  // Dropped words still count down so the frame boundary stays intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_out   <= 32'd0;
      r_word_valid <= 1'b0;
      r_word_last  <= 1'b0;
    end else if (w_buf_load) begin
      r_word_out   <= parallel_in;
      r_word_valid <= 1'b1;
      r_word_last  <= w_pay_last;
    end else if (r_word_valid && word_ready) begin
      r_word_valid <= 1'b0;
      r_word_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_err <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      if (w_hdr_done && !w_hdr_bad && w_len_big) begin
        r_len_err <= 1'b1;
      end
      if (w_buf_drop) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  assign word_out     = r_word_out;
  assign word_valid   = r_word_valid;
  assign word_last    = r_word_last;
  assign len_err      = r_len_err;
  assign overflow_err = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_deser_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_deser_ctrl
//  Purpose  : Self-checking bench for noc_deser_ctrl with a frame-level model
//             and a payload scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_noc_deser_ctrl;

  localparam int C    = 4;
  localparam int WMAX = 16;
  localparam int BIG  = 1 << 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        sof;
  logic        done_word;
  logic [31:0] parallel_in;
  logic        shift_en;
  logic        deser_reset;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic        busy;
  logic        len_err;
  logic        overflow_err;
`ifdef NOC_DESER_HDR_CHECK_EN
  logic        hdr_err;
`endif

  always #5 clk = ~clk;

  noc_deser_ctrl #(.CLKS_PER_BIT(C), .WORDS_MAX(WMAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .sof          (sof),
    .done_word    (done_word),
    .parallel_in  (parallel_in),
    .shift_en     (shift_en),
    .deser_reset  (deser_reset),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_last    (word_last),
    .busy         (busy),
    .len_err      (len_err),
    .overflow_err (overflow_err)
`ifdef NOC_DESER_HDR_CHECK_EN
    ,
    .hdr_err      (hdr_err)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fixed_pay[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Frame model: cycle of ALIGN, first HEADER cycle, first idle cycle.
  int m_align = -100;
  int m_base  = -100;
  int m_end   = 0;
  int m_fr    = 0;
  int m_left  = 0;
  bit m_full  = 0;
  bit m_len_err = 0;
  bit m_ovf   = 0;
  bit m_hdr_err = 0;
  bit m_wzero = 1;

  bit e_shift, e_dr, e_busy, e_valid, e_len, e_ovf, e_hdr, e_wzero;
  bit chk_en   = 0;
  bit end_req  = 0;
  bit end_done = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("shift_en", {31'd0, shift_en}, {31'd0, e_shift});
      chk("deser_reset", {31'd0, deser_reset}, {31'd0, e_dr});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("word_valid", {31'd0, word_valid}, {31'd0, e_valid});
      chk("len_err", {31'd0, len_err}, {31'd0, e_len});
      chk("overflow_err", {31'd0, overflow_err}, {31'd0, e_ovf});
`ifdef NOC_DESER_HDR_CHECK_EN
      chk("hdr_err", {31'd0, hdr_err}, {31'd0, e_hdr});
`endif
      if (e_wzero) chk("word_out_cleared", word_out, 32'd0);
      if (!reset && word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word cyc=%0d got=%h last=%b required=none", cyc, word_out, word_last);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_out", word_out, e.data);
          chk("word_last", {31'd0, word_last}, {31'd0, e.last});
        end
      end
      if (end_req && !end_done) begin
        chk("words_outstanding", exp_q.size(), 32'd0);
        end_done = 1;
      end
    end
  end

  // Effect of this cycle's inputs, as seen at the end of the cycle.
  task automatic model_cycle(input bit s, input bit d, input logic [31:0] pin,
                             input bit rdy, input bit rst);
    bit   load;
    exp_t e;
    if (rst) begin
      m_align = -100; m_base = -100; m_end = 0; m_fr = 0; m_left = 0;
      m_full = 0; m_len_err = 0; m_ovf = 0; m_hdr_err = 0; m_wzero = 1;
      exp_q.delete();
      return;
    end
    load = 0;
    if (s) begin
      m_align = cyc + 1;
      m_base  = cyc + 2;
      m_end   = BIG;
      m_fr    = 1;
    end else if (d && cyc >= m_base && cyc < m_end) begin
      if (m_fr == 1) begin
`ifdef NOC_DESER_HDR_CHECK_EN
        if (pin[31:24] != 8'hA5) begin
          m_hdr_err = 1;
          m_end = cyc + 1;
        end else
`endif
        if (pin[7:0] == 8'd0) begin
          m_end = cyc + 1;
        end else if (int'(pin[7:0]) > WMAX) begin
          m_len_err = 1;
          m_end = cyc + 1;
        end else begin
          m_left = int'(pin[7:0]);
          m_fr = 2;
        end
      end else begin
        m_left--;
        if (!m_full || rdy) begin
          load   = 1;
          e.data = pin;
          e.last = (m_left == 0);
          exp_q.push_back(e);
        end else begin
          m_ovf = 1;
        end
        if (m_left == 0) m_end = cyc + 1;
      end
    end
    if (load) begin
      m_full  = 1;
      m_wzero = 0;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
  endtask

  task automatic step(input bit s, input bit d, input logic [31:0] pin,
                      input bit rdy, input bit rst);
    sof = s; done_word = d; parallel_in = pin; word_ready = rdy; reset = rst;
    model_cycle(s, d, pin, rdy, rst);
    @(posedge clk);
    #1;
    cyc++;
    e_shift = (cyc >= m_base) && (cyc < m_end) && (((cyc - m_base) % C) == C / 2);
    e_dr    = (cyc == m_align);
    e_busy  = (cyc >= m_align) && (cyc < m_end);
    e_valid = m_full;
    e_len   = m_len_err;
    e_ovf   = m_ovf;
    e_hdr   = m_hdr_err;
    e_wzero = m_wzero;
  endtask

  function automatic bit pick_ready(input int rmode, input int w);
    case (rmode)
      0:       return 1'b1;
      1:       return (w >= 3);
      2:       return ($urandom_range(0, 3) != 0);
      default: return 1'b0;
    endcase
  endfunction

  // Stray done_word pulses are injected only while the model says IDLE.
  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      step(0, (cyc >= m_end) && ($urandom_range(0, 3) == 0), $urandom, rdy, 0);
    end
  endtask

  task automatic run_frame(input logic [31:0] hdr, input int npay,
                           input int ndeliver, input int rmode);
    logic [31:0] words[$];
    int          base;
    int          w;
    bit          r;
    words.push_back(hdr);
    for (int i = 0; i < npay; i++) begin
      words.push_back((i < fixed_pay.size()) ? fixed_pay[i] : $urandom);
    end
    fixed_pay.delete();
    base = cyc + 2;
    step(1, 0, $urandom, pick_ready(rmode, 0), 0);
    w = 0;
    while (w < ndeliver) begin
      r = pick_ready(rmode, w);
      if (cyc == base + (32 * w + 31) * C + C / 2 + 1) begin
        step(0, 1, words[w], r, 0);
        w++;
      end else begin
        step(0, 0, $urandom, r, 0);
      end
    end
  endtask

  initial begin
    int          len;
    int          sel;
    logic [31:0] hdr;
    sof = 0; done_word = 0; parallel_in = 0; word_ready = 0; reset = 1;
    step(0, 0, 32'd0, 0, 1);
    step(0, 0, 32'd0, 0, 1);
    chk_en = 1;
    idle(4, 1);

    fixed_pay.push_back(32'hDEADBEEF);
    fixed_pay.push_back(32'h12345678);
    run_frame(32'hA5000002, 2, 3, 0);
    idle(6, 1);

    run_frame(32'hA5000003, 3, 4, 1);
    idle(6, 1);

    run_frame(32'hA5000000, 0, 1, 0);
    idle(4, 1);
    run_frame(32'hA5000011, 0, 1, 0);
    idle(4, 1);

    run_frame(32'hA5000003, 3, 2, 0);
    run_frame(32'hA5000002, 2, 3, 2);
    idle(6, 1);

    run_frame(32'hA5000003, 3, 2, 3);
    idle(5, 0);
    step(0, 0, $urandom, 0, 1);
    idle(3, 1);
    run_frame(32'hA5000002, 2, 3, 0);
    idle(6, 1);

`ifdef NOC_DESER_HDR_CHECK_EN
    run_frame(32'h5A000002, 2, 1, 0);
    idle(4, 1);
    run_frame(32'hA5000001, 1, 2, 0);
    idle(4, 1);
`endif

    for (int f = 0; f < 8; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = 0;
      else if (sel == 1) len = 17 + $urandom_range(0, 238);
      else               len = $urandom_range(1, 4);
      hdr = {8'hA5, 16'($urandom), 8'(len)};
      if (len == 0 || len > WMAX) run_frame(hdr, 0, 1, 2);
      else                        run_frame(hdr, len, len + 1, 2);
      idle($urandom_range(2, 8), $urandom_range(0, 1) == 1);
    end

    idle(8, 1);
    end_req = 1;
    idle(3, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_deser_ctrl.md
# noc_deser_ctrl

Frame-level controller that sequences the NoC link's 32-bit serial-to-parallel deserializer. It paces bit sampling with `shift_en`, realigns the deserializer at each start of frame, and parses the header word to learn the payload length. Payload words are forwarded to the router ingress through a one-entry valid/ready output buffer. It sits between the PHY-side serial line and the router input port.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clocks per serial bit period; must be ≥ 2.
- `WORDS_MAX`, default 16: largest legal payload length in words; range 1..255.

Ports:
- `clk` input, 1: single clock; all logic is rising-edge.
- `reset` input, 1: synchronous, active-high.
- `sof` input, 1: one-cycle start-of-frame strobe from the line sync detector.
- `done_word` input, 1: deserializer word-complete pulse.
- `parallel_in` input, 32: deserializer word; valid in the cycle `done_word`=1.
- `shift_en` output, 1: one-cycle sample strobe to the deserializer.
- `deser_reset` output, 1: one-cycle realign pulse to the deserializer's reset.
- `word_out` output, 32: payload word.
- `word_valid` output, 1: `word_out` is valid.
- `word_ready` input, 1: consumer accepts the word.
- `word_last` output, 1: `word_out` is the final payload word of its frame.
- `busy` output, 1: state ≠ IDLE.
- `len_err` output, 1: sticky; a header length exceeded WORDS_MAX.
- `overflow_err` output, 1: sticky; a payload word was dropped because the buffer was full.

## Operation
- Reset values:
  - state = IDLE.
  - Outputs `shift_en`, `deser_reset`, `word_valid`, `word_last`, `busy`, `len_err` and `overflow_err` = 0.
  - `word_out` = 0.
  - Phase counter and word counter = 0.
- States and transitions:
  - IDLE → ALIGN on `sof`.
  - ALIGN: drives `deser_reset`=1 and clears the phase counter. Lasts exactly one cycle, then → HEADER.
  - HEADER: bit pacing runs. On `done_word`, capture `len` = `parallel_in[7:0]`, then:
    - `len`=0 → IDLE; header-only frame, no output.
    - `len` > WORDS_MAX → set `len_err`, go to IDLE, drop the frame.
    - otherwise load the word counter with `len` and go to PAYLOAD.
  - PAYLOAD: bit pacing runs. On each `done_word`, present the word to the buffer and decrement the counter. When the counter reaches 0, that word gets `word_last`=1 and the state goes to IDLE.
- Bit pacing (HEADER and PAYLOAD only):
  - The phase counter counts 0..CLKS_PER_BIT−1 and wraps.
  - `shift_en`=1 exactly when phase == CLKS_PER_BIT/2 (integer division).
- Output buffer (one entry):
  - Load when a payload `done_word` arrives and either `word_valid`=0 or `word_ready`=1 in the same cycle. Loading sets `word_valid`=1 in the next cycle.
  - Clear `word_valid` after a cycle with `word_valid` & `word_ready` and no load.
  - If a payload `done_word` arrives while `word_valid`=1 and `word_ready`=0: drop the new word, set `overflow_err`, and keep the held word unchanged. The word counter still decrements, so frame tracking continues.
  - A drop of the last word means no `word_last` is emitted for that frame.
- `sof` outside IDLE aborts the current frame and goes to ALIGN. A word already held in the buffer stays until accepted.
- `done_word` in IDLE or ALIGN is ignored.
- Sticky errors clear only on `reset`.

## Timing
- `sof` sampled at cycle T → ALIGN at T+1 (`deser_reset`=1) → HEADER at T+2 with phase 0.
- Bit k occupies cycles T+2+k·C … T+1+(k+1)·C, where C = CLKS_PER_BIT. Its `shift_en` is at T+2+k·C+C/2.
- The deserializer raises `done_word` one cycle after the 32nd `shift_en` of a word.
- Payload latency: `word_valid` rises one cycle after the `done_word` that loads the word.
- Returning to IDLE at the last `done_word` stops `shift_en` before the next bit; this relies on C ≥ 2.
- `reset` in any cycle overrides everything: same-cycle `sof` and `done_word` are ignored.

## Configuration
- `NOC_DESER_HDR_CHECK_EN` defined:
  - The header must carry magic `parallel_in[31:24]` == 8'hA5.
  - A mismatch sets the sticky output `hdr_err` (port present only under this macro; reset 0) and sends the FSM to IDLE without starting payload.
  - The magic check takes priority over the length checks.
- `NOC_DESER_HDR_CHECK_EN` not defined: bits [31:8] of the header are ignored and the `hdr_err` port does not exist.

## Test plan
- Nominal frame: C=4, `sof` at T, header len=2 (magic A5), then payload 0xDEADBEEF and 0x12345678, `word_ready`=1.
  - `shift_en` first fires at T+4.
  - Two `word_valid` beats; the second has `word_last`=1.
  - `busy` falls after the last `done_word`.
- Backpressure: len=3, hold `word_ready`=0 through the second payload `done_word`.
  - First word stays on `word_out`.
  - Second word is dropped and `overflow_err`=1.
  - Third word loads once the first is accepted.
- Header len=0 → back to IDLE, no `word_valid`. Header len=17 with WORDS_MAX=16 → `len_err`=1, no output.
- `sof` during PAYLOAD after 1 of 3 words → `deser_reset` pulse, new frame parsed correctly, no `word_last` for the aborted frame.
- `reset` asserted mid-PAYLOAD with `word_valid`=1 → all outputs 0 the next cycle; the following `sof` works normally.
- With `NOC_DESER_HDR_CHECK_EN`: header 0x5A000002 → `hdr_err`=1, no payload output. Header 0xA5000001 → one word forwarded with `word_last`=1.
